// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch unit and the control unit it feeds:
// instruction class codes, per-class occupancy and the fetch FSM states.
package cpu_pkg;

  localparam int DEF_INSTR_WIDTH = 20;
  localparam int DEF_ADDR_BITS   = 5;

  // Class field lives in the top two bits of every instruction word
  typedef enum logic [1:0] {
    CLS_HALT   = 2'b00,
    CLS_STD    = 2'b01,
    CLS_LOADR  = 2'b10,
    CLS_STORER = 2'b11
  } instr_class_e;

  // Number of cycles the CU spends on each instruction class
  localparam int LEN_STD    = 3;
  localparam int LEN_LOADR  = 4;
  localparam int LEN_STORER = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  // Counter value on the last cycle of an instruction of the given class.
  // Halt words never sit in RUN, so their entry is only a safe default.
  function automatic logic [1:0] last_cnt(input logic [1:0] cls);
    case (cls)
      CLS_LOADR:  last_cnt = 2'(LEN_LOADR - 1);
      CLS_STORER: last_cnt = 2'(LEN_STORER - 1);
      default:    last_cnt = 2'(LEN_STD - 1);
    endcase
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Small program store: register array with one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset so a
// loaded program survives a reset of the fetch unit.
module instr_mem #(
  parameter int WIDTH = 20,
  parameter int ABITS = 5
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [ABITS-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [ABITS-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [2**ABITS];

  // Write port: the new word becomes readable after the edge
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: steps a PC through the internal program memory and
// holds each word on instr for as long as the CU needs for its class.
// A class-00 word stops fetch until reset.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int ADDR_BITS   = DEF_ADDR_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   ld_en,
  input  logic [ADDR_BITS-1:0]   ld_addr,
  input  logic [INSTR_WIDTH-1:0] ld_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   retire,
  output logic                   halted
);

  fetch_state_e           state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   retire_d;

  logic [ADDR_BITS-1:0]   rd_addr;
  logic [INSTR_WIDTH-1:0] rd_data;
  logic                   mem_we;

  // The program may only be rewritten while fetch is not stepping through it
  assign mem_we = ld_en && (state_q == ST_IDLE || state_q == ST_HALT);

  instr_mem #(
    .WIDTH(INSTR_WIDTH),
    .ABITS(ADDR_BITS)
  ) u_imem (
    .clk_i  (clk),
    .we_i   (mem_we),
    .waddr_i(ld_addr),
    .wdata_i(ld_data),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  // State, PC, counter and presented word; all return to zero on reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: start on run, wait one CU reset-exit cycle, then
  // advance the PC on the last cycle of each instruction
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    retire_d = 1'b0;
    rd_addr  = pc_q + ADDR_BITS'(1);

    case (state_q)
      ST_IDLE: begin
        rd_addr = '0;
        if (run) begin
          instr_d = rd_data;
          pc_d    = '0;
          cnt_d   = '0;
          state_d = (rd_data[INSTR_WIDTH-1 -: 2] == CLS_HALT) ? ST_HALT : ST_PRIME;
        end
      end
      ST_PRIME: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == last_cnt(instr_q[INSTR_WIDTH-1 -: 2])) begin
          retire_d = 1'b1;
          pc_d     = pc_q + ADDR_BITS'(1);
          instr_d  = rd_data;
          cnt_d    = '0;
          if (rd_data[INSTR_WIDTH-1 -: 2] == CLS_HALT) state_d = ST_HALT;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: ;
    endcase
  end

  assign instr  = instr_q;
  assign pc     = pc_q;
  assign retire = retire_d;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch. A cycle-level reference model built
// from the hold-length rules predicts instr/pc/retire/halted every cycle.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        ld_en = 1'b0;
  logic [4:0]  ld_addr = '0;
  logic [19:0] ld_data = '0;
  logic [19:0] instr;
  logic [4:0]  pc;
  logic        retire;
  logic        halted;

  int total = 0;
  int bad = 0;

  logic [19:0] progMem [32];

  instr_fetch dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .ld_en  (ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .instr  (instr),
    .pc     (pc),
    .retire (retire),
    .halted (halted)
  );

  // Free-running clock shared with the notional CU
  always #5 clk = ~clk;

  // Watchdog so a broken design can never hang the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, required finish before it");
    $fatal(1, "[TB] watchdog expired");
  end

  // CU occupancy of a word, from its class field
  function automatic int lenOf(input logic [19:0] w);
    case (w[19:18])
      2'b10:   lenOf = 4;
      default: lenOf = 3;
    endcase
  endfunction

  // Pulse reset asynchronously between clock edges
  task automatic doReset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Write one program word while fetch is in IDLE or HALT
  task automatic loadWord(input int addr, input logic [19:0] data);
    ld_en   = 1'b1;
    ld_addr = 5'(addr);
    ld_data = data;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
    progMem[addr] = data;
  endtask

  // Pulse run, then compare the DUT against the hold-length model each cycle.
  // ldGlitch tries to zero the next word throughout the running phase;
  // ldAtStart writes ldWord to address 0 on the run edge itself.
  task automatic runCheck(input string name, input int cycles, input bit ldGlitch,
                          input bit ldAtStart, input logic [19:0] ldWord,
                          input int expRetires);
    int mPc;
    logic [19:0] mWord;
    int remain;
    bit mHalt;
    bit expRet;
    int retCnt;
    run = 1'b1;
    if (ldAtStart) begin
      ld_en   = 1'b1;
      ld_addr = 5'd0;
      ld_data = ldWord;
    end
    @(posedge clk);
    #1;
    run   = 1'b0;
    ld_en = 1'b0;
    mPc    = 0;
    mWord  = progMem[0];
    mHalt  = (mWord[19:18] == 2'b00);
    remain = lenOf(mWord) + 1;
    if (ldAtStart) progMem[0] = ldWord;
    retCnt = 0;
    for (int c = 0; c < cycles; c++) begin
      expRet = !mHalt && (remain == 1);
      if (ldGlitch && !mHalt) begin
        ld_en   = 1'b1;
        ld_addr = 5'(mPc + 1);
        ld_data = 20'h0;
      end else begin
        ld_en = 1'b0;
      end
      total++;
      if (instr !== mWord || pc !== 5'(mPc) || retire !== expRet || halted !== mHalt) begin
        bad++;
        $display("[TB] FAIL %s cyc%0d: got instr=%h pc=%0d ret=%b halt=%b, want instr=%h pc=%0d ret=%b halt=%b",
                 name, c, instr, pc, retire, halted, mWord, mPc, expRet, mHalt);
      end
      if (retire === 1'b1) retCnt++;
      if (!mHalt) begin
        if (remain == 1) begin
          mPc   = (mPc + 1) % 32;
          mWord = progMem[mPc];
          if (mWord[19:18] == 2'b00) mHalt = 1'b1;
          else remain = lenOf(mWord);
        end else begin
          remain--;
        end
      end
      @(posedge clk);
      #1;
    end
    ld_en = 1'b0;
    if (expRetires >= 0) begin
      total++;
      if (retCnt != expRetires) begin
        bad++;
        $display("[TB] FAIL %s retireCount: got %0d, want %0d", name, retCnt, expRetires);
      end
    end
  endtask

  // Outputs straight out of reset
  task automatic test_reset_values();
    doReset();
    total++;
    if (instr !== 20'h0 || pc !== 5'd0 || retire !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("[TB] FAIL resetValues: got instr=%h pc=%0d ret=%b halt=%b, want all zero",
               instr, pc, retire, halted);
    end
  endtask

  // std then loadR then halt: holds of 4 and 4 cycles, two retires
  task automatic test_std_loadr();
    loadWord(0, 20'h5_1230);
    loadWord(1, 20'h8_0020);
    loadWord(2, 20'h0_0000);
    runCheck("stdLoadr", 16, 1'b0, 1'b0, 20'h0, 2);
  endtask

  // Asynchronous reset mid-instruction clears outputs before the next edge
  task automatic test_reset();
    doReset();
    runCheck("preReset", 5, 1'b0, 1'b0, 20'h0, -1);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (instr !== 20'h0 || pc !== 5'd0 || retire !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("[TB] FAIL asyncReset: got instr=%h pc=%0d ret=%b halt=%b, want all zero",
               instr, pc, retire, halted);
    end
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    runCheck("afterReset", 16, 1'b0, 1'b0, 20'h0, 2);
  endtask

  // storeR first: holds of 4 then 3 cycles, then halt
  task automatic test_storer();
    doReset();
    loadWord(0, 20'hC_0010);
    loadWord(1, 20'h4_0001);
    loadWord(2, 20'h0_0000);
    runCheck("storer", 14, 1'b0, 1'b0, 20'h0, 2);
  endtask

  // Full memory of std words: PC wraps and retire continues every 3 cycles
  task automatic test_wrap();
    doReset();
    for (int a = 0; a < 32; a++) loadWord(a, {2'b01, 18'($urandom)});
    runCheck("wrap", 120, 1'b0, 1'b0, 20'h0, 39);
  endtask

  // Writes during RUN are dropped; the same write in HALT sticks
  task automatic test_ld_during_run();
    doReset();
    loadWord(0, 20'h4_1111);
    loadWord(1, 20'h8_2222);
    loadWord(2, 20'h5_3333);
    loadWord(3, 20'hC_4444);
    loadWord(4, 20'h0_0000);
    runCheck("ldInRun", 24, 1'b1, 1'b0, 20'h0, 4);
    loadWord(1, 20'h0_0000);
    doReset();
    runCheck("ldInHalt", 10, 1'b0, 1'b0, 20'h0, 1);
  endtask

  // run and a write to address 0 on the same edge fetch the old word
  task automatic test_run_ld_same_edge();
    doReset();
    runCheck("sameEdgeOld", 10, 1'b0, 1'b1, 20'h9_0F0F, 1);
    doReset();
    runCheck("sameEdgeNew", 10, 1'b0, 1'b0, 20'h0, 1);
  endtask

  // Halt word at address 0 goes straight to HALT with no PRIME cycle
  task automatic test_halt_first();
    doReset();
    loadWord(0, 20'h0_0ABC);
    runCheck("haltFirst", 5, 1'b0, 1'b0, 20'h0, 0);
  endtask

  // Random programs with a random halt position (or none)
  task automatic test_random();
    int haltAt;
    for (int it = 0; it < 6; it++) begin
      doReset();
      haltAt = $urandom_range(1, 45);
      for (int a = 0; a < 32; a++) begin
        if (a == haltAt) loadWord(a, {2'b00, 18'($urandom)});
        else loadWord(a, {2'($urandom_range(1, 3)), 18'($urandom)});
      end
      runCheck("random", 130, 1'b0, 1'b0, 20'h0, -1);
    end
  endtask

  // Scenario sequence
  initial begin
    for (int a = 0; a < 32; a++) progMem[a] = 20'h0;
    test_reset_values();
    test_std_loadr();
    test_reset();
    test_storer();
    test_wrap();
    test_ld_during_run();
    test_run_ld_same_edge();
    test_halt_first();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
